// File: rtl/noc_link_fc_snd_mvc_if.sv
// Link-sender bundle: per-VC upstream flit handshake, the multiplexed
// physical link, per-VC credit return and sender status flags.
interface noc_link_fc_snd_mvc_if #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_NUM     = 2
);
    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    // Upstream side: one flit lane per VC
    logic [VC_NUM-1:0]            valid_in;
    logic [VC_NUM*DATA_WIDTH-1:0] data_in;
    logic [VC_NUM-1:0]            ready_out;

    // Physical link side
    logic                         valid_out;
    logic [VC_W-1:0]              vc_out;
    logic [DATA_WIDTH-1:0]        data_out;

    // Credit return from the receiver and status
    logic [VC_NUM-1:0]            credit_upd;
    logic [VC_NUM-1:0]            credits_avail;
    logic                         overflow_err;

    // Environment view: drives flits and credits, observes the link
    modport master (
        output valid_in, data_in, credit_upd,
        input  ready_out, valid_out, vc_out, data_out, credits_avail, overflow_err
    );

    // Sender view
    modport slave (
        input  valid_in, data_in, credit_upd,
        output ready_out, valid_out, vc_out, data_out, credits_avail, overflow_err
    );
endinterface

// File: rtl/noc_link_fc_snd_mvc.sv
// Multi-VC credit-based link sender. Keeps one credit counter per virtual
// channel, round-robin arbitrates flit by flit among VCs holding both a
// flit and a credit, and drives the winner onto a single physical link.
module noc_link_fc_snd_mvc #(
    parameter int DATA_WIDTH  = 64,
    parameter int VC_NUM      = 2,
    parameter int MAX_CREDITS = 3,
    parameter int REG_DATA    = 1,
    parameter int REG_CR_UPD  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_link_fc_snd_mvc_if.slave lnk
);
    localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int CNT_W = $clog2(MAX_CREDITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CREDITS);

    logic [CNT_W-1:0]      cnt [VC_NUM];
    logic [VC_W-1:0]       rr;
    logic [VC_NUM-1:0]     cu;
    logic [VC_NUM-1:0]     elig;
    logic [VC_NUM-1:0]     at_max;
    logic [VC_NUM-1:0]     grant;
    logic [VC_NUM-1:0]     send;
    logic [VC_W-1:0]       gnt_id;
    logic                  gnt_any;
    logic [DATA_WIDTH-1:0] mux_data;
    logic                  ovf_hit;

    // Position `off` slots after the round-robin pointer, wrapping at VC_NUM
    function automatic int rr_slot(input int base, input int off);
        return (base + off) % VC_NUM;
    endfunction

    // Applied credit-update bits: straight through or one cycle late
    generate
        if (REG_CR_UPD != 0) begin : g_cu_reg
            logic [VC_NUM-1:0] cu_q;

            // Delay credit returns by one cycle to ease receiver-side timing
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) cu_q <= '0;
                else     cu_q <= lnk.credit_upd;
            end
            assign cu = cu_q;
        end else begin : g_cu_dir
            assign cu = lnk.credit_upd;
        end
    endgenerate

    // Per-VC eligibility, saturation and status flags from counter state
    always_comb begin
        elig              = '0;
        at_max            = '0;
        lnk.credits_avail = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            elig[v]              = lnk.valid_in[v] && (cnt[v] != '0);
            at_max[v]            = (cnt[v] == CNT_MAX);
            lnk.credits_avail[v] = (cnt[v] != '0);
        end
    end

    // Round-robin pick: first eligible VC at or after the pointer wins
    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            if (!gnt_any && elig[rr_slot(int'(rr), i)]) begin
                grant[rr_slot(int'(rr), i)] = 1'b1;
                gnt_id  = VC_W'(rr_slot(int'(rr), i));
                gnt_any = 1'b1;
            end
        end
    end

    // No acceptance while reset is held; grant implies valid, so send = grant
    assign send          = rst ? '0 : grant;
    assign lnk.ready_out = send;

    // Flit selected by the arbiter; zero when the link is idle
    assign mux_data = (|send) ? lnk.data_in[gnt_id*DATA_WIDTH +: DATA_WIDTH] : '0;

    // Return without a send into a full counter means the receiver over-credited
    assign ovf_hit = |(cu & ~send & at_max);

    // Advance the pointer past the granted VC; hold it when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= '0;
        end else if (|send) begin
            rr <= (int'(gnt_id) == VC_NUM - 1) ? '0 : gnt_id + 1'b1;
        end
    end

    // Credit counters: -1 per send, +1 per return, saturate at full
    // NOTE: the counter array is reset, because credits must start at the receiver depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) cnt[v] <= CNT_MAX;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (send[v] && !cu[v])                cnt[v] <= cnt[v] - 1'b1;
                else if (!send[v] && cu[v] && !at_max[v]) cnt[v] <= cnt[v] + 1'b1;
            end
        end
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          lnk.overflow_err <= 1'b0;
        else if (ovf_hit) lnk.overflow_err <= 1'b1;
    end

    // Link output stage: registered or combinational from the grant mux
    generate
        if (REG_DATA != 0) begin : g_out_reg
            logic                  valid_q;
            logic [VC_W-1:0]       vc_q;
            logic [DATA_WIDTH-1:0] data_q;

            // Register the granted flit; valid drops on a cycle without grant
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    vc_q    <= '0;
                    data_q  <= '0;
                end else begin
                    valid_q <= |send;
                    vc_q    <= gnt_id;
                    data_q  <= mux_data;
                end
            end
            assign lnk.valid_out = valid_q;
            assign lnk.vc_out    = vc_q;
            assign lnk.data_out  = data_q;
        end else begin : g_out_comb
            assign lnk.valid_out = |send;
            assign lnk.vc_out    = (|send) ? gnt_id : '0;
            assign lnk.data_out  = mux_data;
        end
    endgenerate
endmodule
